dino_frame_composer: RTL and testbench
======================================

Name: dino_frame_composer

Overview:
- Upstream pixel source for the OLED SPI screen driver; replaces its combinational pattern logic.
- Holds two 1024-byte frame buffers in SSD1306 page-major layout. The driver reads the front buffer by pixelIndex while an FSM renders the next frame into the back buffer.
- Each rendered frame contains ground, dino and one cactus. Buffers swap only at the driver's end-of-frame, so the display never tears.

Parameters:
- DINO_X, 8, left column of the 16x16 dino sprite.
- CACTUS_TOP, 47, top row of the 8x16 cactus (bottom row 62).
- GROUND_ROW, 63, row carrying the ground line.
- DASH_MASK, 7, a ground pixel is cleared when ((col+scroll) & DASH_MASK) == DASH_MASK.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pixelIndex  in  10  driver byte address; page = [9:7], col = [6:0]
- frameNumber  in  8  driver frame counter; bit 2 selects the dino leg frame
- gameon  in  1  high = game running; low = freeze scene inputs
- dino_y  in  6  dino top row; values >48 are clamped to 48
- obstacle_x  in  8  cactus left column; 128..255 is fully off-screen
- scroll  in  8  ground dash phase
- patternByte  out  8  front-buffer byte at pixelIndex; bit0 is the top row of the page
- render_busy  out  1  high while the back buffer is being written
- frame_ready  out  1  back buffer complete and waiting for swap

Behaviour:
- Reset:
  - patternByte = 0, render_busy = 0, frame_ready = 0.
  - front_sel = 0, blank = 1, state = LATCH, addr = 0.
  - Buffer RAM is not cleared.
- Read path:
  - patternByte = blank ? 0 : front[pixelIndex], asynchronous (LUT RAM), valid in the same cycle as pixelIndex.
  - The driver samples patternByte one cycle after pixelIndex changes, so the read needs zero latency.
- Swap condition (sw):
  - Registered pixelIndex_d == 1023 and pixelIndex == 0. This is the driver's end of data phase, and its counter wraps to 0 in 10 bits.
  - sw only takes effect in state DONE.
- FSM:
  - LATCH (1 cycle):
    - If gameon = 1: latch clamped dino_y, obstacle_x, scroll, and leg = frameNumber[2].
    - If gameon = 0: keep the previous latched values and force leg = 0.
    - Set addr = 0, go to RENDER.
  - RENDER (1024 cycles):
    - Each cycle write back[addr] = byte(addr), then addr + 1.
    - After addr = 1023 is written, go to DONE.
    - render_busy = 1 throughout.
  - DONE:
    - frame_ready = 1.
    - On sw: toggle front_sel, clear blank, go to LATCH.
    - A sw seen in LATCH or RENDER is ignored. The old front is shown again and no swap is queued.
- byte(addr), with P = page, C = col; it is the OR of three terms:
  - Ground: if P == GROUND_ROW>>3, set bit (GROUND_ROW & 7) unless the dash rule clears it.
  - Dino:
    - Applies when C - DINO_X is in 0..15, using 9-bit unsigned compare.
    - w = dino_rom[leg][C-DINO_X], 16-bit column word, bit0 = top.
    - m = ({48'b0, w} << y), 64 bits.
    - Contribution = m[8P+7:8P].
  - Cactus:
    - Applies when C >= obstacle_x and C - obstacle_x <= 7, using 9-bit arithmetic so there is no wrap.
    - Same mapping as the dino, using cactus_rom with fixed shift CACTUS_TOP.
- Sprite ROMs are combinational constants, 2 frames x 16 columns x 16 bits for the dino and 8 x 16 for the cactus. The bench holds a golden copy.
- The write address and data may be registered one stage, provided the 1024 writes finish before DONE is asserted.
- Render time is about 1026 cycles per frame, well inside the driver's frame wait. A swap is missed only if frames arrive faster than the render time.
- rst_n asserted mid-RENDER aborts the render. The FSM restarts in LATCH and blank stays 1 until the next completed swap.

Test Plan:
- Reset release, then drive 1023->0 on pixelIndex before render finishes -> no swap and patternByte = 0. After frame_ready, the next 1023->0 makes blank = 0.
- gameon=1, dino_y=48, obstacle_x=200, scroll=0, after swap -> bytes 896..1023 show ground with the dash pattern (0x80 except where (col&7)==7 gives 0x00). Page 6/7 cols 8..23 equal the golden dino OR ground. No cactus pixels.
- obstacle_x=124 -> cactus drawn only in cols 124..127, pages 5..7. Col 0 of pages 5..7 matches ground/dino only, proving no wrap.
- dino_y=63 -> rendered identically to dino_y=48. dino_y=3 -> the sprite straddles pages 0..2 with bits shifted by 3.
- gameon 1->0 with dino_y changed from 20 to 40 -> the next frame keeps y=20 and uses leg frame 0.
- rst_n pulsed low at addr 500 of a render -> outputs return to reset values. A full render and swap then complete normally and match the golden image.

Source files
------------

// File: rtl/dino_frame_composer.sv
// dino_frame_composer: double-buffered SSD1306 page-major frame store.
// The driver reads the front buffer by pixelIndex while an FSM renders
// ground, dino and cactus into the back buffer; buffers swap only at the
// driver's end-of-frame (pixelIndex 1023 -> 0).
module dino_frame_composer #(
  parameter int unsigned DINO_X     = 8,
  parameter int unsigned CACTUS_TOP = 47,
  parameter int unsigned GROUND_ROW = 63,
  parameter int unsigned DASH_MASK  = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pixelIndex,
  input  logic [7:0] frameNumber,
  input  logic       gameon,
  input  logic [5:0] dino_y,
  input  logic [7:0] obstacle_x,
  input  logic [7:0] scroll,
  output logic [7:0] patternByte,
  output logic       render_busy,
  output logic       frame_ready
);

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned SPR_H    = 16;
  localparam int unsigned COLUMN_W = 64;
  localparam int unsigned DINO_W   = 16;
  localparam int unsigned CACTUS_W = 8;
  localparam int unsigned Y_MAX    = 48;
  localparam int unsigned LAST_A   = 1023;

  typedef enum logic [1:0] {
    ST_LATCH  = 2'd0,
    ST_RENDER = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                front_sel_q, front_sel_d;
  logic                blank_q, blank_d;
  logic [5:0]          y_q, y_d;
  logic [7:0]          obs_q, obs_d;
  logic [7:0]          scr_q, scr_d;
  logic                leg_q, leg_d;
  logic [ADDR_W-1:0]   pix_prev_q;
  logic                render_busy_q, frame_ready_q;

  logic                sw_c;
  logic                we_c;
  logic [BYTE_W-1:0]   wdata_c;
  logic [5:0]          y_clamp_c;

  // Two 1024-byte buffers; the MSB of the address selects the buffer.
  logic [BYTE_W-1:0]   fb_mem [2**(ADDR_W+1)];

  // Sprite column words, bit0 = top row of the sprite.
  function automatic logic [SPR_H-1:0] dino_rom(input logic leg, input logic [3:0] idx);
    logic [SPR_H-1:0] w;
    case ({leg, idx})
      5'h00, 5'h10: w = 16'h0380;
      5'h01, 5'h11: w = 16'h07C0;
      5'h02, 5'h12: w = 16'h0FC0;
      5'h03:        w = 16'h1FC0;
      5'h04:        w = 16'h3FC0;
      5'h05:        w = 16'h7FE0;
      5'h06:        w = 16'hFFF0;
      5'h13:        w = 16'h3FC0;
      5'h14:        w = 16'h1FC0;
      5'h15:        w = 16'hFFE0;
      5'h16:        w = 16'h7FF0;
      5'h07, 5'h17: w = 16'h3FFC;
      5'h08, 5'h18: w = 16'h0FFE;
      5'h09, 5'h19: w = 16'h07FF;
      5'h0A, 5'h1A: w = 16'h07FD;
      5'h0B, 5'h1B: w = 16'h07FF;
      5'h0C, 5'h1C: w = 16'h03DF;
      5'h0D, 5'h1D: w = 16'h019F;
      5'h0E, 5'h1E: w = 16'h001E;
      default:      w = 16'h000C;
    endcase
    return w;
  endfunction

  function automatic logic [SPR_H-1:0] cactus_rom(input logic [2:0] idx);
    logic [SPR_H-1:0] w;
    case (idx)
      3'd0:    w = 16'h00F0;
      3'd1:    w = 16'h01F8;
      3'd2:    w = 16'h00F0;
      3'd3:    w = 16'hFFFF;
      3'd4:    w = 16'hFFFF;
      3'd5:    w = 16'h0F00;
      3'd6:    w = 16'h1F80;
      default: w = 16'h0F00;
    endcase
    return w;
  endfunction

  // Zero-latency front-buffer read; blank hides a buffer never rendered.
  assign patternByte = blank_q ? 8'h00 : fb_mem[{front_sel_q, pixelIndex}];
  assign render_busy = render_busy_q;
  assign frame_ready = frame_ready_q;

  // Driver end-of-frame: its counter wraps 1023 -> 0.
  assign sw_c = (pix_prev_q == 10'(LAST_A)) && (pixelIndex == 10'd0);

  assign y_clamp_c = (dino_y > 6'(Y_MAX)) ? 6'(Y_MAX) : dino_y;

  // Byte generator for the render address: ground | dino | cactus.
  always_comb begin
    logic [2:0]          page;
    logic [6:0]          col;
    logic [7:0]          dash_sum;
    logic [8:0]          dino_off;
    logic [8:0]          cac_off;
    logic [COLUMN_W-1:0] dino_m;
    logic [COLUMN_W-1:0] cac_m;
    logic [BYTE_W-1:0]   gnd_b;
    logic [BYTE_W-1:0]   dino_b;
    logic [BYTE_W-1:0]   cac_b;
    page     = addr_q[9:7];
    col      = addr_q[6:0];
    dash_sum = {1'b0, col} + scr_q;
    dino_off = 9'(col) - 9'(DINO_X);
    cac_off  = 9'(col) - 9'(obs_q);
    dino_m   = COLUMN_W'(dino_rom(leg_q, dino_off[3:0])) << y_q;
    cac_m    = COLUMN_W'(cactus_rom(cac_off[2:0])) << CACTUS_TOP;
    gnd_b    = '0;
    dino_b   = '0;
    cac_b    = '0;
    if ((page == 3'(GROUND_ROW >> 3)) &&
        ((dash_sum & 8'(DASH_MASK)) != 8'(DASH_MASK))) begin
      gnd_b[3'(GROUND_ROW % 8)] = 1'b1;
    end
    if (dino_off < 9'(DINO_W)) begin
      dino_b = dino_m[{page, 3'b000} +: BYTE_W];
    end
    if ((9'(col) >= 9'(obs_q)) && (cac_off < 9'(CACTUS_W))) begin
      cac_b = cac_m[{page, 3'b000} +: BYTE_W];
    end
    wdata_c = gnd_b | dino_b | cac_b;
  end

  // Next-state: latch scene, render 1024 bytes, wait for the driver swap.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    front_sel_d = front_sel_q;
    blank_d     = blank_q;
    y_d         = y_q;
    obs_d       = obs_q;
    scr_d       = scr_q;
    leg_d       = leg_q;
    we_c        = 1'b0;
    case (state_q)
      ST_LATCH: begin
        if (gameon) begin
          y_d   = y_clamp_c;
          obs_d = obstacle_x;
          scr_d = scroll;
          leg_d = frameNumber[2];
        end else begin
          leg_d = 1'b0;
        end
        addr_d  = '0;
        state_d = ST_RENDER;
      end
      ST_RENDER: begin
        we_c   = 1'b1;
        addr_d = addr_q + 10'd1;
        if (addr_q == 10'(LAST_A)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (sw_c) begin
          front_sel_d = ~front_sel_q;
          blank_d     = 1'b0;
          state_d     = ST_LATCH;
        end
      end
      default: state_d = ST_LATCH;
    endcase
  end

  // State, scene latches and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_LATCH;
      addr_q        <= '0;
      front_sel_q   <= 1'b0;
      blank_q       <= 1'b1;
      y_q           <= '0;
      obs_q         <= 8'hFF;
      scr_q         <= '0;
      leg_q         <= 1'b0;
      pix_prev_q    <= '0;
      render_busy_q <= 1'b0;
      frame_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      front_sel_q   <= front_sel_d;
      blank_q       <= blank_d;
      y_q           <= y_d;
      obs_q         <= obs_d;
      scr_q         <= scr_d;
      leg_q         <= leg_d;
      pix_prev_q    <= pixelIndex;
      render_busy_q <= (state_d == ST_RENDER);
      frame_ready_q <= (state_d == ST_DONE);
    end
  end

  // Back-buffer write port; RAM contents are not reset.
  always_ff @(posedge clk) begin
    if (we_c) begin
      fb_mem[{~front_sel_q, addr_q}] <= wdata_c;
    end
  end

endmodule

// File: tb/tb_dino_frame_composer.sv
// Directed bench for dino_frame_composer with a per-pixel golden renderer.
module tb_dino_frame_composer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pixelIndex;
  logic [7:0] frameNumber;
  logic       gameon;
  logic [5:0] dino_y;
  logic [7:0] obstacle_x;
  logic [7:0] scroll;
  logic [7:0] patternByte;
  logic       render_busy;
  logic       frame_ready;

  int checks   = 0;
  int failures = 0;

  logic [15:0] dino_g [2][16];
  logic [15:0] cac_g  [8];

  dino_frame_composer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixelIndex  (pixelIndex),
    .frameNumber (frameNumber),
    .gameon      (gameon),
    .dino_y      (dino_y),
    .obstacle_x  (obstacle_x),
    .scroll      (scroll),
    .patternByte (patternByte),
    .render_busy (render_busy),
    .frame_ready (frame_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Pixel-by-pixel reference of one display byte.
  function automatic logic [7:0] gold(input int a, input int y, input int obs,
                                      input int scr, input int leg);
    int p, c, r;
    logic [7:0]  b;
    logic [15:0] w;
    p = a / 128;
    c = a % 128;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      r = 8 * p + k;
      if (r == 63 && ((c + scr) % 8) != 7) b[k] = 1'b1;
      if (c >= 8 && c < 24 && r >= y && r < y + 16) begin
        w = dino_g[leg][c-8];
        if (w[r-y]) b[k] = 1'b1;
      end
      if (c >= obs && (c - obs) <= 7 && r >= 47 && r < 63) begin
        w = cac_g[c-obs];
        if (w[r-47]) b[k] = 1'b1;
      end
    end
    return b;
  endfunction

  task automatic peek(input int a, output logic [7:0] v);
    pixelIndex = 10'(a);
    #1;
    v = patternByte;
  endtask

  task automatic byte_chk(input string tag, input int a, input logic [7:0] exp);
    logic [7:0] v;
    peek(a, v);
    check_eq(tag, 32'(v), 32'(exp));
    pixelIndex = 10'd1;
  endtask

  task automatic frame_cmp(input string tag, input int y, input int obs,
                           input int scr, input int leg);
    int errs;
    logic [7:0] v;
    errs = 0;
    for (int a = 0; a < 1024; a++) begin
      peek(a, v);
      if (v !== gold(a, y, obs, scr, leg)) errs++;
    end
    check_eq(tag, 32'(errs), 32'd0);
    pixelIndex = 10'd1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (frame_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(frame_ready), 32'd1);
    check_eq({tag, "_busy"}, 32'(render_busy), 32'd0);
  endtask

  task automatic do_swap();
    @(negedge clk) pixelIndex = 10'd1023;
    @(negedge clk) pixelIndex = 10'd0;
    @(negedge clk) pixelIndex = 10'd1;
  endtask

  task automatic set_scene(input logic g, input int y, input int obs,
                           input int scr, input int fn);
    gameon      = g;
    dino_y      = 6'(y);
    obstacle_x  = 8'(obs);
    scroll      = 8'(scr);
    frameNumber = 8'(fn);
  endtask

  initial begin
    dino_g[0] = '{16'h0380, 16'h07C0, 16'h0FC0, 16'h1FC0, 16'h3FC0, 16'h7FE0,
                  16'hFFF0, 16'h3FFC, 16'h0FFE, 16'h07FF, 16'h07FD, 16'h07FF,
                  16'h03DF, 16'h019F, 16'h001E, 16'h000C};
    dino_g[1] = '{16'h0380, 16'h07C0, 16'h0FC0, 16'h3FC0, 16'h1FC0, 16'hFFE0,
                  16'h7FF0, 16'h3FFC, 16'h0FFE, 16'h07FF, 16'h07FD, 16'h07FF,
                  16'h03DF, 16'h019F, 16'h001E, 16'h000C};
    cac_g = '{16'h00F0, 16'h01F8, 16'h00F0, 16'hFFFF, 16'hFFFF, 16'h0F00,
              16'h1F80, 16'h0F00};

    rst_n      = 1'b0;
    pixelIndex = 10'd1;
    set_scene(1'b1, 48, 200, 0, 0);
    repeat (3) @(negedge clk);
    check_eq("rst_pattern", 32'(patternByte), 32'd0);
    check_eq("rst_busy", 32'(render_busy), 32'd0);
    check_eq("rst_ready", 32'(frame_ready), 32'd0);
    rst_n = 1'b1;

    // Swap attempt during the first render must be ignored.
    repeat (20) @(negedge clk);
    check_eq("busy_first", 32'(render_busy), 32'd1);
    check_eq("ready_first", 32'(frame_ready), 32'd0);
    do_swap();
    byte_chk("early_swap_blank", 896, 8'h00);
    wait_ready("ready0");

    // Frame A: y=48, cactus off-screen, scroll 0, leg 0.
    set_scene(1'b1, 3, 124, 5, 4);
    do_swap();
    @(negedge clk);
    check_eq("busy_after_swap", 32'(render_busy), 32'd1);
    byte_chk("gnd_col0", 896, 8'h80);
    byte_chk("gnd_col7", 903, 8'h00);
    byte_chk("gnd_col100", 996, 8'h80);
    byte_chk("gnd_col127", 1023, 8'h00);
    byte_chk("dino_p7_c8", 904, 8'h83);
    byte_chk("dino_p6_c8", 776, 8'h80);
    frame_cmp("frameA", 48, 200, 0, 0);
    wait_ready("ready1");

    // Frame B: y=3 straddling pages 0..2, cactus at 124 clipped, leg 1.
    set_scene(1'b1, 63, 200, 0, 0);
    do_swap();
    byte_chk("y3_p0_c14", 14, 8'h80);
    byte_chk("y3_p1_c14", 142, 8'hFF);
    byte_chk("y3_p2_c14", 270, 8'h03);
    byte_chk("y3_p1_c9", 137, 8'h3E);
    byte_chk("cac_p5_c127", 767, 8'h80);
    byte_chk("cac_p6_c127", 895, 8'hFF);
    byte_chk("cac_p7_c127", 1023, 8'hFF);
    byte_chk("cac_p6_c124", 892, 8'h78);
    byte_chk("cac_p7_c124", 1020, 8'h80);
    byte_chk("nowrap_p5_c0", 640, 8'h00);
    byte_chk("nowrap_p6_c0", 768, 8'h00);
    byte_chk("nowrap_p7_c0", 896, 8'h80);
    frame_cmp("frameB", 3, 124, 5, 1);
    wait_ready("ready2");

    // Frame C: dino_y=63 clamps to 48.
    set_scene(1'b1, 20, 60, 2, 4);
    do_swap();
    frame_cmp("frameC_clamp", 48, 200, 0, 0);
    wait_ready("ready3");

    // Frame D: running scene, leg 1.
    set_scene(1'b0, 40, 10, 7, 4);
    do_swap();
    frame_cmp("frameD", 20, 60, 2, 1);
    wait_ready("ready4");

    // Frame E: gameon low keeps y=20/obs=60/scroll=2 and forces leg 0.
    set_scene(1'b1, 10, 30, 1, 0);
    do_swap();
    frame_cmp("frameE_freeze", 20, 60, 2, 0);

    // Reset in the middle of a render.
    repeat (501) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_pattern", 32'(patternByte), 32'd0);
    check_eq("midrst_busy", 32'(render_busy), 32'd0);
    check_eq("midrst_ready", 32'(frame_ready), 32'd0);
    set_scene(1'b1, 30, 100, 3, 4);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("postrst_busy", 32'(render_busy), 32'd1);
    byte_chk("postrst_blank", 1023, 8'h00);
    wait_ready("ready5");
    byte_chk("ready5_blank", 1023, 8'h00);
    set_scene(1'b1, 0, 0, 0, 0);
    do_swap();
    frame_cmp("frameF", 30, 100, 3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
